// File: rtl/alu_wb_pkg.sv
// Shared types and constants for the ALU writeback stage.
package alu_wb_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned RADDR_W = 4;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned DEPTH   = 2;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [RADDR_W-1:0] rd;
        logic               we;
        logic               setflags;
        logic               n;
        logic               z;
        logic               c;
        logic               v;
    } wb_entry_t;

    // Pack an entry's flag bits into the committed {N,Z,C,V} layout.
    function automatic logic [3:0] entry_flags(input wb_entry_t e);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = e.n;
        f[FLAG_Z] = e.z;
        f[FLAG_C] = e.c;
        f[FLAG_V] = e.v;
        return f;
    endfunction

endpackage

// File: rtl/alu_wb_if.sv
// ALU-result input and register-file write handshakes of the writeback stage.
interface alu_wb_if;
    import alu_wb_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_result;
    logic               in_carry;
    logic               in_overflow;
    logic               in_zero;
    logic               in_negative;
    logic [RADDR_W-1:0] in_rd;
    logic               in_we;
    logic               in_setflags;
    logic               out_valid;
    logic               out_ready;
    logic               out_we;
    logic [RADDR_W-1:0] out_rd;
    logic [DATA_W-1:0]  out_data;

    modport slave (
        input  in_valid, in_result, in_carry, in_overflow, in_zero, in_negative,
               in_rd, in_we, in_setflags, out_ready,
        output in_ready, out_valid, out_we, out_rd, out_data
    );

    modport master (
        output in_valid, in_result, in_carry, in_overflow, in_zero, in_negative,
               in_rd, in_we, in_setflags, out_ready,
        input  in_ready, out_valid, out_we, out_rd, out_data
    );

endinterface

// File: rtl/wb_skid_fifo.sv
// Two-entry elastic buffer of writeback entries; ready, valid and head are all registered.
module wb_skid_fifo
    import alu_wb_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      in_valid,
    output logic      in_ready,
    input  wb_entry_t in_entry,
    output logic      out_valid,
    input  logic      out_ready,
    output wb_entry_t out_entry
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    wb_entry_t          mem_q [DEPTH];
    wb_entry_t          mem_n [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_n;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_n;
    logic [OCC_W-1:0]   occ_q, occ_n;
    logic               push;
    logic               pop;

    // Next buffer state; the head register is loaded from the post-update view.
    always_comb begin
        push     = in_valid && in_ready;
        pop      = out_valid && out_ready;
        mem_n    = mem_q;
        wr_ptr_n = wr_ptr_q;
        rd_ptr_n = rd_ptr_q;
        if (push) begin
            mem_n[wr_ptr_q] = in_entry;
            wr_ptr_n = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_n = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        occ_n = occ_q + OCC_W'(push) - OCC_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_entry <= '0;
        end else begin
            mem_q     <= mem_n;
            wr_ptr_q  <= wr_ptr_n;
            rd_ptr_q  <= rd_ptr_n;
            occ_q     <= occ_n;
            in_ready  <= (occ_n != OCC_W'(DEPTH));
            out_valid <= (occ_n != '0);
            out_entry <= (occ_n != '0) ? mem_n[rd_ptr_n] : '0;
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// Execute-to-writeback stage: buffers ALU results, drives the register-file
// write port, commits NZCV in retire order and counts retired operations.
module alu_wb_stage
    import alu_wb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    alu_wb_if.slave          bus,
    output logic [3:0]       flags,
    output logic [CNT_W-1:0] retired_cnt
);

    wb_entry_t in_entry;
    wb_entry_t head;
    logic      head_valid;
    logic      fifo_ready;
    logic      retire;

    always_comb begin
        in_entry          = '0;
        in_entry.data     = bus.in_result;
        in_entry.rd       = bus.in_rd;
        in_entry.we       = bus.in_we;
        in_entry.setflags = bus.in_setflags;
        in_entry.n        = bus.in_negative;
        in_entry.z        = bus.in_zero;
        in_entry.c        = bus.in_carry;
        in_entry.v        = bus.in_overflow;
    end

    wb_skid_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (fifo_ready),
        .in_entry  (in_entry),
        .out_valid (head_valid),
        .out_ready (bus.out_ready),
        .out_entry (head)
    );

    // The head register is zeroed whenever the buffer is empty.
    assign bus.in_ready  = fifo_ready;
    assign bus.out_valid = head_valid;
    assign bus.out_we    = head.we;
    assign bus.out_rd    = head.rd;
    assign bus.out_data  = head.data;

    assign retire = head_valid && bus.out_ready;

    // Architectural flags and the retire counter only move on a retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags       <= '0;
            retired_cnt <= '0;
        end else if (retire) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
            if (head.setflags) begin
                flags <= entry_flags(head);
            end
        end
    end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Randomized scoreboard bench for alu_wb_stage against a queue-based reference.
module tb_alu_wb_stage;
    import alu_wb_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       flags;
    logic [CNT_W-1:0] retired_cnt;

    alu_wb_if bus();

    alu_wb_stage dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .flags       (flags),
        .retired_cnt (retired_cnt)
    );

    initial forever #5 clk = ~clk;

    int               ncmp = 0;
    int               nfail = 0;
    wb_entry_t        exp_q[$];
    wb_entry_t        mon_h;
    wb_entry_t        acc_e;
    logic [3:0]       mflags = 4'b0000;
    logic [CNT_W-1:0] mcnt = '0;
    bit               rand_done = 1'b0;
    int               gap;
    longint           t_start;
    longint           t_end;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic wb_entry_t make(input logic [15:0] d, input logic [3:0] rd,
                                       input logic we, input logic sf, input logic [3:0] nzcv);
        wb_entry_t e;
        e.data = d; e.rd = rd; e.we = we; e.setflags = sf;
        e.n = nzcv[3]; e.z = nzcv[2]; e.c = nzcv[1]; e.v = nzcv[0];
        return e;
    endfunction

    function automatic wb_entry_t rand_entry();
        return make(16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
    endfunction

    task automatic drive(input wb_entry_t e);
        bus.in_result   = e.data;
        bus.in_rd       = e.rd;
        bus.in_we       = e.we;
        bus.in_setflags = e.setflags;
        bus.in_negative = e.n;
        bus.in_zero     = e.z;
        bus.in_carry    = e.c;
        bus.in_overflow = e.v;
    endtask

    // Offer one entry and hold it until the stage accepts it.
    task automatic send(input wb_entry_t e);
        bit ok;
        ok = 1'b0;
        drive(e);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            ncmp++; nfail++;
            $display("FAIL send_timeout: entry %0h never accepted", e);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            ncmp++; nfail++;
            $display("FAIL drain_timeout: out_valid still %0b", bus.out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Accept tracker: records every entry the stage takes at the coming edge.
    always @(negedge clk) begin
        #1;
        if (!rst && bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
            acc_e = make(bus.in_result, bus.in_rd, bus.in_we, bus.in_setflags,
                         {bus.in_negative, bus.in_zero, bus.in_carry, bus.in_overflow});
            exp_q.push_back(acc_e);
        end
    end

    // Output monitor: compares the presented head and state, then retires in the model.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mflags = 4'b0000;
            mcnt   = '0;
        end else begin
            chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < 2));
            if (exp_q.size() != 0) begin
                mon_h = exp_q[0];
                chk("out_data", 32'(bus.out_data), 32'(mon_h.data));
                chk("out_rd", 32'(bus.out_rd), 32'(mon_h.rd));
                chk("out_we", 32'(bus.out_we), 32'(mon_h.we));
            end else begin
                chk("idle_data", 32'(bus.out_data), 32'd0);
                chk("idle_rd", 32'(bus.out_rd), 32'd0);
                chk("idle_we", 32'(bus.out_we), 32'd0);
            end
            chk("flags", 32'(flags), 32'(mflags));
            chk("retired_cnt", 32'(retired_cnt), 32'(mcnt));
            if (exp_q.size() != 0 && bus.out_ready === 1'b1) begin
                mon_h = exp_q.pop_front();
                mcnt  = mcnt + 1'b1;
                if (mon_h.setflags) mflags = {mon_h.n, mon_h.z, mon_h.c, mon_h.v};
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles while upstream asserts valid.
        bus.out_ready = 1'b0;
        drive(make(16'hBEEF, 4'd7, 1'b1, 1'b1, 4'b1111));
        bus.in_valid = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_cnt", 32'(retired_cnt), 32'd0);
        @(posedge clk); #1;

        // Single pass-through.
        bus.out_ready = 1'b1;
        send(make(16'h00FF, 4'd3, 1'b1, 1'b1, 4'b0010));
        @(negedge clk);
        chk("pt_out_valid", 32'(bus.out_valid), 32'd1);
        chk("pt_out_data", 32'(bus.out_data), 32'h00FF);
        chk("pt_out_rd", 32'(bus.out_rd), 32'd3);
        @(posedge clk); #1;
        @(negedge clk);
        chk("pt_flags", 32'(flags), 32'b0010);
        chk("pt_cnt", 32'(retired_cnt), 32'd1);
        @(posedge clk); #1;

        // Backpressure: two fill the buffer, the third waits for a free slot.
        bus.out_ready = 1'b0;
        fork
            begin
                send(make(16'd1, 4'd1, 1'b1, 1'b0, 4'b0000));
                send(make(16'd2, 4'd2, 1'b1, 1'b0, 4'b0000));
                send(make(16'd3, 4'd3, 1'b1, 1'b0, 4'b0000));
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
                chk("bp_head_held", 32'(bus.out_data), 32'd1);
                @(posedge clk); #1;
                bus.out_ready = 1'b1;
            end
        join
        drain();
        @(negedge clk);
        chk("bp_cnt", 32'(retired_cnt), 32'd4);
        chk("bp_flags_kept", 32'(flags), 32'b0010);
        @(posedge clk); #1;

        // Flags commit at retire only, and only for setflags entries.
        do_reset();
        bus.out_ready = 1'b0;
        send(make(16'h1234, 4'd5, 1'b1, 1'b1, 4'b0100));
        repeat (3) begin
            @(negedge clk);
            chk("fo_flags_pending", 32'(flags), 32'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        drain();
        @(negedge clk);
        chk("fo_flags_a", 32'(flags), 32'b0100);
        @(posedge clk); #1;
        send(make(16'h5678, 4'd6, 1'b1, 1'b0, 4'b1000));
        drain();
        @(negedge clk);
        chk("fo_flags_b", 32'(flags), 32'b0100);
        @(posedge clk); #1;

        // Continuous accept and retire at occupancy 1: one entry per cycle.
        do_reset();
        bus.out_ready = 1'b1;
        t_start = $time;
        for (int i = 0; i < 10; i++) send(rand_entry());
        t_end = $time;
        chk("stream_cycles", 32'((t_end - t_start) / 10), 32'd10);
        drain();
        @(negedge clk);
        chk("stream_cnt", 32'(retired_cnt), 32'd10);
        @(posedge clk); #1;

        // Randomized traffic with random gaps and random backpressure.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    gap = $urandom_range(0, 2);
                    repeat (gap) begin
                        @(posedge clk); #1;
                    end
                    send(rand_entry());
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        drain();

        // Counter wrap from FFFF to 0.
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 65535; i++) send(make(16'(i), 4'(i), 1'b0, 1'b0, 4'(i)));
        drain();
        @(negedge clk);
        chk("wrap_ffff", 32'(retired_cnt), 32'h0000FFFF);
        @(posedge clk); #1;
        send(make(16'hAAAA, 4'd9, 1'b1, 1'b0, 4'b0000));
        drain();
        @(negedge clk);
        chk("wrap_zero", 32'(retired_cnt), 32'd0);
        @(posedge clk); #1;

        // Reset with two entries buffered discards them and clears state.
        send(make(16'h0F0F, 4'd2, 1'b1, 1'b1, 4'b1000));
        drain();
        bus.out_ready = 1'b0;
        send(make(16'hCAFE, 4'd4, 1'b1, 1'b1, 4'b0001));
        send(make(16'hF00D, 4'd8, 1'b1, 1'b1, 4'b0011));
        @(negedge clk);
        chk("mr_flags_before", 32'(flags), 32'b1000);
        chk("mr_full", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        do_reset();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("mr_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mr_flags", 32'(flags), 32'd0);
        chk("mr_cnt", 32'(retired_cnt), 32'd0);
        chk("mr_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        repeat (4) begin
            @(negedge clk);
            chk("mr_no_ghost", 32'(bus.out_valid), 32'd0);
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
